// File: rtl/decoder_pkg.sv
// decoder_pkg: shared RV32 decode constants, operation enums and the decoded-entry record.
package decoder_pkg;
  localparam int XLEN = 32;
  localparam int RW = 5;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_NONE
  } alu_op_t;
  typedef enum logic [2:0] {
    SX_I = 3'b000, SX_S = 3'b001, SX_R = 3'b010, SX_NONE = 3'b111
  } sx_op_t;
  typedef struct packed {
    alu_op_t         alu_op;
    sx_op_t          sx_op;
    logic [XLEN-1:0] imm;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            illegal;
  } decoded_t;
  localparam decoded_t DEC_ILLEGAL = '{ALU_NONE, SX_NONE, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1};
  localparam decoded_t DEC_RESET   = '{ALU_NONE, SX_NONE, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0};
  // Shared funct3 map of OP and OP-IMM; ALU_NONE marks an unsupported funct3.
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3);
    return f3 == F3_ADD ? ALU_ADD :
           f3 == F3_AND ? ALU_AND :
           f3 == F3_OR  ? ALU_OR  :
           f3 == F3_XOR ? ALU_XOR :
           f3 == F3_SLT ? ALU_SLT :
           f3 == F3_SLL ? ALU_SLL : ALU_NONE;
  endfunction
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational instruction word to decoded_t translation.
module decode_comb
  import decoder_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output decoded_t        o_dec
);
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [RW-1:0]   w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  alu_op_t         w_f3_alu;
  logic            w_op_ok;
  assign w_opc    = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_rd     = i_instr[11:7];
  assign w_imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_f3_alu = f3_to_alu(w_f3);
  assign w_op_ok  = (w_f7 == F7_BASE && w_f3_alu != ALU_NONE) || (w_f7 == F7_ALT && w_f3 == F3_ADD);
  always_comb begin
    o_dec = DEC_ILLEGAL;
    if (w_opc == OPC_LOAD && w_f3 == F3_WORD)
      o_dec = '{ALU_ADD, SX_I, w_imm_i, 1'b1, 1'b0, 1'b1, w_rs1, '0, w_rd, 1'b0};
    else if (w_opc == OPC_STORE && w_f3 == F3_WORD)
      o_dec = '{ALU_ADD, SX_S, w_imm_s, 1'b0, 1'b1, 1'b0, w_rs1, w_rs2, '0, 1'b0};
    else if (w_opc == OPC_OPIMM && w_f3_alu != ALU_NONE)
      o_dec = '{w_f3_alu, SX_I, w_imm_i, 1'b0, 1'b0, 1'b1, w_rs1, '0, w_rd, 1'b0};
    else if (w_opc == OPC_OP && w_op_ok)
      o_dec = '{w_f7 == F7_ALT ? ALU_SUB : w_f3_alu, SX_R, '0, 1'b0, 1'b0, 1'b1, w_rs1, w_rs2, w_rd, 1'b0};
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, back-pressured RV32 decode stage with a two-entry skid buffer,
// flush support and a saturating illegal-instruction counter.
module decode_stage
  import decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int RWD = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [2:0]            alu_op,
  output logic [2:0]            sx_op,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [RWD-1:0]        rs1,
  output logic [RWD-1:0]        rs2,
  output logic [RWD-1:0]        rd,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  illegal_count
);
  decoded_t              w_dec;
  decoded_t              r_main;
  decoded_t              r_skid;
  logic [DATA_WIDTH-1:0] r_main_pc;
  logic [DATA_WIDTH-1:0] r_skid_pc;
  logic                  r_main_v;
  logic                  r_skid_v;
  logic                  r_in_ready;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_accept;
  logic                  w_emit;
  logic                  w_main_free;
  logic                  w_main_v_nxt;
  logic                  w_skid_v_nxt;
  decode_comb u_dec (.i_instr(in_instr), .o_dec(w_dec));
  assign w_accept    = in_valid & r_in_ready;
  assign w_emit      = r_main_v & out_ready;
  assign w_main_free = !r_main_v | w_emit;
  // The skid only ever holds an entry while main is full, so a freed main takes the skid first.
  assign w_main_v_nxt = w_main_free ? (r_skid_v | w_accept) : 1'b1;
  assign w_skid_v_nxt = w_main_free ? 1'b0 : (r_skid_v | w_accept);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main     <= DEC_RESET;
      r_skid     <= DEC_RESET;
      r_main_pc  <= '0;
      r_skid_pc  <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
      r_cnt      <= '0;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_main_free && (r_skid_v || w_accept)) begin
        r_main    <= r_skid_v ? r_skid : w_dec;
        r_main_pc <= r_skid_v ? r_skid_pc : in_pc;
      end
      if (!w_main_free && w_accept) begin
        r_skid    <= w_dec;
        r_skid_pc <= in_pc;
      end
      r_main_v   <= w_main_v_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= !w_skid_v_nxt;
      if (w_accept && w_dec.illegal && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end
  assign in_ready      = r_in_ready;
  assign out_valid     = r_main_v;
  assign out_pc        = r_main_pc;
  assign alu_op        = r_main.alu_op;
  assign sx_op         = r_main.sx_op;
  assign imm           = r_main.imm;
  assign mem_read      = r_main.mem_read;
  assign mem_write     = r_main.mem_write;
  assign reg_write     = r_main.reg_write;
  assign rs1           = r_main.rs1;
  assign rs2           = r_main.rs2;
  assign rd            = r_main.rd;
  assign illegal       = r_main.illegal;
  assign illegal_count = r_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a queue-based reference model.
module tb_decode_stage;
  localparam int CW = 6;
  localparam logic [CW-1:0] CMAX = '1;
  typedef struct packed {
    logic [2:0]  alu;
    logic [2:0]  sx;
    logic [31:0] imm;
    logic        mr, mw, rw;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;
  localparam exp_t RST_O = '{3'd7, 3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0};
  localparam exp_t ILL_O = '{3'd7, 3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1};
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [2:0] alu_op, sx_op;
  logic mem_read, mem_write, reg_write, illegal;
  logic [4:0] rs1, rs2, rd;
  logic [CW-1:0] illegal_count;
  exp_t dut_o;
  int n_tests = 0, n_fail = 0, n_emit = 0;
  ent_t q[$];
  logic [CW-1:0] m_cnt = '0;
  decode_stage #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .alu_op(alu_op), .sx_op(sx_op), .imm(imm), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal), .illegal_count(illegal_count)
  );
  assign dut_o = {alu_op, sx_op, imm, mem_read, mem_write, reg_write, rs1, rs2, rd, illegal};
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: classify the instruction by its format rules and fill the fields it defines.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [2:0] f3, op;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    op = (f3 == 3'd0) ? 3'd0 : (f3 == 3'd7) ? 3'd2 : (f3 == 3'd6) ? 3'd3 :
         (f3 == 3'd4) ? 3'd4 : (f3 == 3'd2) ? 3'd5 : (f3 == 3'd1) ? 3'd6 : 3'd7;
    e = ILL_O;
    if (w[6:0] == 7'h03 && f3 == 3'd2) begin
      e = '{3'd0, 3'd0, 32'($signed(w[31:20])), 1'b1, 1'b0, 1'b1, w[19:15], 5'd0, w[11:7], 1'b0};
    end else if (w[6:0] == 7'h23 && f3 == 3'd2) begin
      e = '{3'd0, 3'd1, 32'($signed({w[31:25], w[11:7]})), 1'b0, 1'b1, 1'b0, w[19:15], w[24:20], 5'd0, 1'b0};
    end else if (w[6:0] == 7'h13 && op != 3'd7) begin
      e = '{op, 3'd0, 32'($signed(w[31:20])), 1'b0, 1'b0, 1'b1, w[19:15], 5'd0, w[11:7], 1'b0};
    end else if (w[6:0] == 7'h33 && ((f7 == 7'h00 && op != 3'd7) || (f7 == 7'h20 && f3 == 3'd0))) begin
      e = '{(f7 == 7'h20) ? 3'd1 : op, 3'd2, 32'd0, 1'b0, 1'b0, 1'b1, w[19:15], w[24:20], w[11:7], 1'b0};
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'h03;
      1: w[6:0] = 7'h23;
      2: w[6:0] = 7'h13;
      3: begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
      4: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
      default: ;
    endcase
    if ((w[6:0] == 7'h03 || w[6:0] == 7'h23) && $urandom_range(0, 3) != 0) w[14:12] = 3'b010;
    return w;
  endfunction

  function automatic logic [31:0] rnd_legal();
    logic [31:0] w;
    w = 32'h00000013;
    for (int i = 0; i < 100; i++) begin
      w = rnd_instr();
      if (!model(w).ill) break;
    end
    return model(w).ill ? 32'h00000013 : w;
  endfunction

  // Scoreboard: every cycle the DUT must match the queue's occupancy, head entry and illegal count.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = '0;
    end else begin
      n_tests++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL occupancy: out_valid=%b in_ready=%b, expected entries=%0d", out_valid, in_ready, q.size());
      end
      n_tests++;
      if (illegal_count !== m_cnt) begin
        n_fail++;
        $display("FAIL illegal_count: got %0d expected %0d", illegal_count, m_cnt);
      end
      if (out_valid === 1'b1 && q.size() != 0) begin
        n_tests++;
        if (dut_o !== model(q[0].ins) || out_pc !== q[0].pc) begin
          n_fail++;
          $display("FAIL head_entry: got %h pc %h expected %h pc %h (instr %h)", dut_o, out_pc, model(q[0].ins), q[0].pc, q[0].ins);
        end
      end
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) begin
          void'(q.pop_front());
          n_emit++;
        end
        if (in_valid && in_ready) begin
          q.push_back('{in_instr, in_pc});
          if (model(in_instr).ill && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_o !== RST_O || out_pc !== 32'd0 || illegal_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b r=%b o=%h pc=%h cnt=%0d expected o=%h", out_valid, in_ready, dut_o, out_pc, illegal_count, RST_O);
    end
  endtask

  task automatic test_load();
    out_ready = 1'b1;
    send(32'h000AAA83, 32'h100);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 ||
        dut_o !== exp_t'{3'd0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd21, 5'd0, 5'd21, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_decode: v=%b pc=%h got %h", out_valid, out_pc, dut_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'h00000000, 32'h104);
    n_tests++;
    if (out_valid !== 1'b1 || dut_o !== ILL_O) begin
      n_fail++;
      $display("FAIL illegal_zero: got %h expected %h", dut_o, ILL_O);
    end
    send(32'hFFFFFFFF, 32'h108);
    n_tests++;
    if (out_valid !== 1'b1 || dut_o !== ILL_O) begin
      n_fail++;
      $display("FAIL illegal_ones: got %h expected %h", dut_o, ILL_O);
    end
    n_tests++;
    if (illegal_count !== CW'(2)) begin
      n_fail++;
      $display("FAIL illegal_count_two: got %0d expected 2", illegal_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    out_ready = 1'b1;
    send(32'hFE512E23, 32'h10C);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10C ||
        dut_o !== exp_t'{3'd0, 3'd1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 5'd2, 5'd5, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_decode: v=%b pc=%h got %h", out_valid, out_pc, dut_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = 32'h200;
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_instr = rnd_legal();
      in_pc = base + 32'(4 * k);
      @(negedge clk);
      if (k > 0) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== base + 32'(4 * (k - 1))) begin
          n_fail++;
          $display("FAIL stream_consecutive[%0d]: v=%b pc=%h expected pc %h", k, out_valid, out_pc, base + 32'(4 * (k - 1)));
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ins[8];
    int sent, emit0;
    logic seen_block, rdy;
    sent = 0; emit0 = n_emit; seen_block = 1'b0;
    for (int i = 0; i < 8; i++) ins[i] = rnd_instr();
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid = (sent < 8);
      in_instr = ins[sent < 8 ? sent : 7];
      in_pc = 32'h300 + 32'(4 * sent);
      rdy = in_ready;
      if (!rdy) seen_block = 1'b1;
      @(posedge clk);
      if (in_valid && rdy) sent++;
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (seen_block !== 1'b1 || sent != 8 || n_emit - emit0 != 8) begin
      n_fail++;
      $display("FAIL backpressure: blocked=%b sent=%0d emitted=%0d expected 1/8/8", seen_block, sent, n_emit - emit0);
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] c0;
    out_ready = 1'b0;
    send(rnd_legal(), 32'h400);
    send(rnd_legal(), 32'h404);
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL both_full: v=%b r=%b expected 1/0", out_valid, in_ready);
    end
    c0 = illegal_count;
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== c0) begin
      n_fail++;
      $display("FAIL flush_full: v=%b r=%b cnt=%0d expected 0/1/%0d", out_valid, in_ready, illegal_count, c0);
    end
    send(rnd_legal(), 32'h408);
    c0 = illegal_count;
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== c0) begin
      n_fail++;
      $display("FAIL flush_drops_accept: v=%b r=%b cnt=%0d expected 0/1/%0d", out_valid, in_ready, illegal_count, c0);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = rnd_instr();
      in_pc = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: v=%b model entries=%0d expected 0/0", out_valid, q.size());
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      in_valid = 1'b1;
      in_instr = {$urandom_range(0, 1) == 1 ? 25'h1FFFFFF : 25'h0, 7'h7F};
      @(posedge clk); #1;
      if (i == 61) begin
        n_tests++;
        if (illegal_count !== CW'(62)) begin
          n_fail++;
          $display("FAIL count_near_max: got %0d expected 62", illegal_count);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (illegal_count !== CMAX) begin
      n_fail++;
      $display("FAIL count_saturate: got %0d expected %0d", illegal_count, CMAX);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = rnd_legal();
    in_pc = 32'h500;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_o !== RST_O || out_pc !== 32'd0 || illegal_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b r=%b o=%h pc=%h cnt=%0d", out_valid, in_ready, dut_o, out_pc, illegal_count);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00000013, 32'h600);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h600 || illegal_count !== '0) begin
      n_fail++;
      $display("FAIL after_reset: v=%b pc=%h cnt=%0d", out_valid, out_pc, illegal_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_load();
    test_illegal();
    test_store();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_saturate();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
